// File: rtl/dcache_pkg.sv
// Shared field widths, controller states and address helpers for the data cache controller.
package dcache_pkg;

  localparam int TAG_W = 5;
  localparam int IDX_W = 8;
  localparam int OFF_W = 3;
  localparam int WORDS = 4;
  localparam int CNT_W = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DRAIN,
    S_FINISH
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  function automatic addr_t addr_fields(input logic [15:0] a);
    return addr_t'(a);
  endfunction

  // Byte address of word `word` within the line {tag, idx}.
  function automatic logic [15:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx,
                                            input logic [CNT_W-1:0] word);
    return {tag, idx, word, 1'b0};
  endfunction

endpackage

// File: rtl/dcache_ret_pipe.sv
// Fill-return tracker: a DEPTH-deep valid+offset shift register that lines up each
// memory read with the cycle its data appears on m_data_out.
module dcache_ret_pipe
  import dcache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [OFF_W-1:0] i_offset,
  output logic             o_out_valid,
  output logic [OFF_W-1:0] o_out_offset,
  output logic             o_empty
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][OFF_W-1:0] r_offset;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= '0;
    end else begin
      // NOTE: shift registers use non-blocking assignments so each stage takes its neighbour's old value.
      r_valid[0] <= i_push;
      for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // NOTE: the offset stages are deliberately not reset; r_valid qualifies every use of them.
  always_ff @(posedge clk) begin
    r_offset[0] <= i_offset;
    for (int i = 1; i < DEPTH; i++) r_offset[i] <= r_offset[i-1];
  end

  assign o_out_valid  = r_valid[DEPTH-1];
  assign o_out_offset = r_offset[DEPTH-1];

  // Empty means nothing remains behind the output stage: the pipe drains this cycle.
  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (r_valid[i]) o_empty = 1'b0;
    end
  end

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional ALIGN_CHECK_EN: odd-address requests complete at once with err=1 and no access.
module dcache_ctrl_fsm #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        c_en,
  output logic        c_comp,
  output logic        c_write,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [4:0]  c_tag_in,
  output logic [15:0] c_data_in,
  output logic        c_valid_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out
);
  import dcache_pkg::*;

  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  addr_t            w_a;
  logic [OFF_W-1:0] w_off;
  logic             w_push, w_ret_valid, w_ret_empty;
  logic [OFF_W-1:0] w_ret_off;

  assign w_a   = addr_fields(Addr);
  assign w_off = w_a.off & 3'b110;

  dcache_ret_pipe #(.DEPTH(MEM_LAT)) u_ret_pipe (
    .clk          (clk),
    .i_clear      (rst),
    .i_push       (w_push),
    .i_offset     ({r_cnt, 1'b0}),
    .o_out_valid  (w_ret_valid),
    .o_out_offset (w_ret_off),
    .o_empty      (w_ret_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WB || r_state == S_FILL) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output is defaulted before the case so no path through it infers a latch.
    w_next     = r_state;
    w_push     = 1'b0;
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    c_en       = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_index    = '0;
    c_offset   = '0;
    c_tag_in   = '0;
    c_data_in  = '0;
    c_valid_in = 1'b0;
    m_addr     = '0;
    m_data_in  = '0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    if (!rst) begin
      c_index  = w_a.idx;
      c_tag_in = w_a.tag;
      case (r_state)
        S_IDLE: begin
          if (Rd && Wr) begin
            err = 1'b1;
`ifdef ALIGN_CHECK_EN
          end else if ((Rd || Wr) && Addr[0]) begin
            err  = 1'b1;
            Done = 1'b1;
`endif
          end else if (Rd || Wr) begin
            c_en       = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = 1'b1;
            c_offset   = w_off;
            c_data_in  = DataIn;
            if (c_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              Stall  = 1'b1;
              w_next = (c_valid && c_dirty) ? S_WB : S_FILL;
            end
          end
        end
        S_WB: begin
          Stall     = 1'b1;
          c_en      = 1'b1;
          c_offset  = {r_cnt, 1'b0};
          m_wr      = 1'b1;
          m_addr    = line_addr(c_tag_out, w_a.idx, r_cnt);
          m_data_in = c_data_out;
          if (r_cnt == CNT_W'(WORDS - 1)) w_next = S_FILL;
        end
        S_FILL: begin
          Stall  = 1'b1;
          m_rd   = 1'b1;
          m_addr = line_addr(w_a.tag, w_a.idx, r_cnt);
          w_push = 1'b1;
          if (r_cnt == CNT_W'(WORDS - 1)) w_next = S_DRAIN;
        end
        S_DRAIN: begin
          Stall = 1'b1;
          if (w_ret_empty) w_next = S_FINISH;
        end
        S_FINISH: begin
          c_en       = 1'b1;
          c_comp     = 1'b1;
          c_write    = Wr;
          c_valid_in = 1'b1;
          c_offset   = w_off;
          c_data_in  = DataIn;
          Done       = 1'b1;
          DataOut    = c_data_out;
          w_next     = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
      // Returned fill data is written as soon as it arrives, overlapping the read issue.
      if (w_ret_valid) begin
        c_en       = 1'b1;
        c_comp     = 1'b0;
        c_write    = 1'b1;
        c_offset   = w_ret_off;
        c_tag_in   = w_a.tag;
        c_valid_in = 1'b1;
        c_data_in  = m_data_out;
      end
    end
  end

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Controller for the direct-mapped, write-back, write-allocate data cache.
- Sits between the pipeline memory stage, which issues Rd/Wr and watches Stall/Done, and the four-bank main memory.
- Drives the external cache array and the memory ports, and produces CacheHit/Done/Stall.
- The processor-level hit and request counters are fed from these outputs.

Parameters:
- MEM_LAT, 2, cycles from memory read issue to mem_data_out valid (≥1).
- WORDS, 4, 16-bit words per line (fixed 4; offset field is 3 bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Addr  in  16  byte address; tag=[15:11], index=[10:3], offset=[2:0]
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid when Done
- Done  out  1  access completes this cycle
- Stall  out  1  requester must hold Addr/DataIn/Rd/Wr
- CacheHit  out  1  request hit on first lookup
- err  out  1  illegal request
- c_en  out  1  cache array enable
- c_comp  out  1  compare mode
- c_write  out  1  cache write
- c_index  out  8  index
- c_offset  out  3  offset
- c_tag_in  out  5  tag to cache
- c_data_in  out  16  data to cache
- c_valid_in  out  1  valid bit to write
- c_hit  in  1  tag match and valid
- c_dirty  in  1  victim dirty
- c_valid  in  1  line valid
- c_tag_out  in  5  victim tag
- c_data_out  in  16  cache word
- m_addr  out  16  memory address
- m_data_in  out  16  write-back data
- m_wr  out  1  memory write
- m_rd  out  1  memory read
- m_data_out  in  16  memory read data

Behaviour:
- Reset: state IDLE; word and return counters 0; all outputs 0.
- States: IDLE, WB, FILL, DRAIN, FINISH.
- IDLE:
  - Idle cycle: c_en=0.
  - Rd^Wr: c_en=1, c_comp=1, c_write=Wr, c_valid_in=1.
  - On c_hit: Done=1, CacheHit=1, Stall=0, DataOut=c_data_out. The hit completes in the request cycle (0-cycle latency).
  - On miss with c_valid & c_dirty: Stall=1, go to WB.
  - On other miss: Stall=1, go to FILL.
- WB: 4 cycles, cnt=0..3.
  - c_comp=0, c_write=0, c_offset={cnt,0}.
  - m_wr=1, m_addr={c_tag_out,index,cnt,0}, m_data_in=c_data_out.
  - After cnt=3: go to FILL.
- FILL: 4 cycles.
  - m_rd=1, m_addr={Addr tag,index,cnt,0}.
  - The offset is pushed into a MEM_LAT-deep return pipe.
  - After cnt=3: go to DRAIN.
- Return writes (FILL and DRAIN): whenever the return pipe output is valid, c_en=1, c_comp=0, c_write=1, c_offset=returned offset, c_tag_in=Addr tag, c_valid_in=1, c_data_in=m_data_out.
- DRAIN: wait until the pipe is empty, then go to FINISH.
- FINISH: replay as a compare access.
  - Done=1, Stall=0, CacheHit=0, DataOut=c_data_out.
  - A store writes DataIn, setting dirty.
  - Next state IDLE.
- Stall is 1 in WB/FILL/DRAIN and in an IDLE miss cycle.
- Latency (issue in cycle 0):
  - Clean miss: Done at cycle 5+MEM_LAT.
  - Dirty miss: Done at cycle 9+MEM_LAT.
- Rd&Wr both high in IDLE: err=1 for that cycle, no cache/memory access, Done=0, Stall=0.
- Request inputs change during Stall: behaviour undefined; the bench flags it.
- rst mid-miss: return to IDLE next edge. In-flight returns are dropped (pipe cleared); the partial line keeps its old valid state only for words not yet written. The bench only checks the line after a new miss refills it.
- Back-to-back requests: a new request may be presented in the cycle after Done.

Optional Feature:
- ALIGN_CHECK_EN.
- Defined: Rd|Wr with Addr[0]=1 in IDLE gives err=1, Done=1, Stall=0, no cache/memory access, DataOut=0.
- Undefined: Addr[0] is ignored (treated as 0).

Decomposition:
- Package dcache_pkg holds:
  - the state enum
  - TAG_W=5, IDX_W=8, OFF_W=3
  - WORDS
  - field-extract helper functions
- Sub-module dcache_ret_pipe: MEM_LAT-deep valid+offset shift register with clear (rst/abort). Exposes out_valid, out_offset and empty.

Test Plan:
- Cold load Addr=0x0010 -> Stall cycles 0..6; m_rd at 0x0010,0x0012,0x0014,0x0016; Done cycle 7, CacheHit=0; then reload 0x0010 -> Done+CacheHit same cycle.
- Store 0x0012 data 0xBEEF after fill -> hit in 1 cycle; evict via load 0x0812 (same index, tag 1) -> m_wr 0x0010..0x0016 with 0x0012=0xBEEF; Done at cycle 11.
- Rd=Wr=1 -> err=1 one cycle, no m_rd/m_wr, Done=0.
- rst asserted during DRAIN -> next cycle all outputs 0, state IDLE; the following load of the same line performs a full refill.
- Back-to-back hits to 0x0010,0x0014,0x0016 -> Done every cycle, no Stall, DataOut matches stored words.
- ALIGN_CHECK_EN: load 0x0011 -> err=1, Done=1 same cycle, no memory traffic; without the macro it behaves as 0x0010.
